// File: rtl/oclib_pkg.sv
// Shared types and helpers for the oclib async req/ack arbiter.
// Holds the handshake state encoding and the round-robin winner search.
package oclib_pkg;

    localparam int MaxPorts = 16;

    typedef enum logic [1:0] {
        StReset,
        StIdle,
        StReq,
        StWait
    } oclib_async_arb_state_e;

    // Returns the first set bit of valid, scanning upward from last+1 with wrap
    // at nports; returns last when nothing is valid.
    function automatic int RoundRobinPick(
        input logic [MaxPorts-1:0] valid,
        input int                  last,
        input int                  nports = MaxPorts
    );
        int   pick;
        int   idx;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MaxPorts; k++) begin
            idx = (last + k) % nports;
            if (k <= nports && !found && valid[idx[3:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/oclib_synchronizer.sv
// Multi-flop synchronizer for signals arriving from another clock domain.
module oclib_synchronizer #(
    parameter int Width      = 1,
    parameter int SyncCycles = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [SyncCycles-1:0][Width-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < SyncCycles; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[SyncCycles-1];

endmodule

// File: rtl/oclib_async_req_ack_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack link between several
// ready/valid requesters; each word is tagged with its source port index.
module oclib_async_req_ack_arbiter
    import oclib_pkg::*;
#(
    parameter int Width         = 8,
    parameter int Ports         = 4,
    parameter int SyncCycles    = 3,
    parameter int TimeoutCycles = 1024,
    localparam int IdWidth      = (Ports > 2) ? $clog2(Ports) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Ports*Width-1:0]   inData,
    input  logic [Ports-1:0]         inValid,
    output logic [Ports-1:0]         inReady,
    output logic [IdWidth+Width-1:0] outData,
    output logic                     outReq,
    input  logic                     outAck,
    input  logic                     clearError,
    output logic                     timeoutError,
    output logic [IdWidth-1:0]       lastGrant
);

    localparam int RstCntW = (SyncCycles > 1) ? $clog2(SyncCycles + 1) : 1;

    oclib_async_arb_state_e     state_q, state_d;
    logic [RstCntW-1:0]         rst_cnt_q, rst_cnt_d;
    logic                       out_req_q, out_req_d;
    logic [IdWidth+Width-1:0]   out_data_q, out_data_d;
    logic [IdWidth-1:0]         last_grant_q, last_grant_d;
    logic [Ports-1:0]           in_ready;
    logic [IdWidth-1:0]         pick_id;
    logic                       ack_sync;

    oclib_synchronizer #(
        .Width      (1),
        .SyncCycles (SyncCycles)
    ) u_ack_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .data_i (outAck),
        .data_o (ack_sync)
    );

    assign pick_id = IdWidth'(RoundRobinPick(MaxPorts'(inValid), int'(last_grant_q), Ports));

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        out_req_d    = out_req_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        in_ready     = '0;
        case (state_q)
            // Let the synchronizer refill with live outAck before trusting it.
            StReset: begin
                if (rst_cnt_q == RstCntW'(SyncCycles - 1)) begin
                    state_d = StWait;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (|inValid) begin
                    for (int i = 0; i < Ports; i++) begin
                        if (pick_id == IdWidth'(i)) begin
                            in_ready[i] = 1'b1;
                            out_data_d  = {pick_id, inData[i*Width +: Width]};
                        end
                    end
                    out_req_d    = 1'b1;
                    last_grant_d = pick_id;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (ack_sync) begin
                    out_req_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (!ack_sync) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StReset;
            rst_cnt_q    <= '0;
            out_req_q    <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= IdWidth'(Ports - 1);
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            out_req_q    <= out_req_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    generate
        if (TimeoutCycles > 0) begin : g_timeout
            localparam int CntW = $clog2(TimeoutCycles + 1);
            localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

            logic [CntW-1:0] cnt_q, cnt_d;
            logic            err_q, err_d;
            logic            running;
            logic            set_err;

            // The flag is set once per stalled handshake, so a clear sticks
            // even while the counter sits saturated.
            always_comb begin
                running = (state_q == StReq) || (state_q == StWait);
                cnt_d   = cnt_q;
                if (state_d == StIdle) begin
                    cnt_d = '0;
                end else if (running && cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                set_err = running && (cnt_d == CntMax) && (cnt_q != CntMax);
                err_d   = err_q;
                if (set_err) begin
                    err_d = 1'b1;
                end else if (clearError) begin
                    err_d = 1'b0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    err_q <= err_d;
                end
            end

            assign timeoutError = err_q;
        end else begin : g_no_timeout
            logic clear_unused;
            assign clear_unused = clearError;
            assign timeoutError = 1'b0;
        end
    endgenerate

    assign inReady   = in_ready;
    assign outData   = out_data_q;
    assign outReq    = out_req_q;
    assign lastGrant = last_grant_q;

endmodule
